mac_tx_arb: RTL

Transmit-side arbiter sharing the single MAC frame encoder between the ARP responder and the IPv4 transmit path. It grants one requester per frame, latches that frame's destination MAC and ethertype, and muxes the requester's payload byte stream onto the encoder's handshake. It enforces an inter-frame idle period and a maximum-length watchdog. It sits between the protocol engines (fed by `mac_decode` results) and the MAC/RGMII transmit chain, in the TX clock domain.

---
 rtl/eth_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/mac_tx_arb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: ethertypes, address width, arbiter state encoding.
package eth_pkg;

  localparam int          MAC_ADDR_W     = 48;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  // Requester select encoding used by the TX arbiter.
  localparam logic SEL_ARP = 1'b0;
  localparam logic SEL_IP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_IFG   = 3'd4
  } mac_tx_arb_state_t;

  // Ethertype carried by the frame of the selected requester.
  function automatic logic [15:0] ethertype_of(input logic sel);
    return (sel == SEL_IP) ? ETHERTYPE_IPV4 : ETHERTYPE_ARP;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: fixed priority (requester A wins ties) or round-robin using a
// last-served pointer. The pointer only moves when the caller commits a grant.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b1
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active low
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic advance_i,  // grant committed this cycle
  output logic any_o,
  output logic pick_b_o
);

  // 1 = B was served last; reset value makes A win the first tie.
  logic last_b_q;

  // Winner selection from current requests and the last-served pointer.
  always_comb begin
    any_o    = req_a_i | req_b_i;
    pick_b_o = req_b_i;
    if (req_a_i && req_b_i) begin
      pick_b_o = FIXED_PRIO ? 1'b0 : ~last_b_q;
    end
  end

  // Last-served pointer, updated only when a grant is committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b_q <= 1'b1;
    end else if (advance_i && any_o) begin
      last_b_q <= pick_b_o;
    end
  end

endmodule

// File: rtl/mac_tx_arb.sv
// Transmit arbiter sharing one MAC frame encoder between the ARP responder and
// the IPv4 path: per-frame grant, header latch, payload mux, inter-frame gap
// and a maximum-length watchdog.
//
// Handshake rule (all payload streams): a byte transfers on a rising clk edge
// where valid and ready are both high; valid/data/last hold until that edge,
// ready may change freely and never waits on valid.
module mac_tx_arb
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1500,
  parameter bit ARP_PRIO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  // ARP requester
  input  logic                  arp_req,
  output logic                  arp_gnt,
  input  logic [MAC_ADDR_W-1:0] arp_da,
  input  logic [7:0]            arp_data,
  input  logic                  arp_valid,
  input  logic                  arp_last,
  output logic                  arp_ready,
  // IPv4 requester
  input  logic                  ip_req,
  output logic                  ip_gnt,
  input  logic [MAC_ADDR_W-1:0] ip_da,
  input  logic [7:0]            ip_data,
  input  logic                  ip_valid,
  input  logic                  ip_last,
  output logic                  ip_ready,
  // Encoder side
  output logic                  mac_start,
  output logic [MAC_ADDR_W-1:0] mac_da,
  output logic [15:0]           mac_ethertype,
  output logic [7:0]            mac_data,
  output logic                  mac_valid,
  output logic                  mac_last,
  input  logic                  mac_ready,
  output logic                  tx_abort,
  // Debug view of the FSM
  output mac_tx_arb_state_t     dbg_state_o
);

  localparam int          IFG_W    = 16;
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES - 1);
  localparam logic [10:0] BEAT_MAX = 11'(MAX_LEN - 1);

  mac_tx_arb_state_t     state_q;
  logic                  sel_q;
  logic [MAC_ADDR_W-1:0] da_q;
  logic [15:0]           etype_q;
  logic [10:0]           beat_q;
  logic [IFG_W-1:0]      ifg_q;
  logic                  abort_q;

  logic any_req;
  logic pick_ip;
  logic grant_now;
  logic sel_valid;
  logic sel_last;
  logic [7:0] sel_data;
  logic sel_ready;
  logic wd_beat;
  logic owning;
  logic xfer_hs;

  assign grant_now = (state_q == ST_IDLE) && any_req;

  rr_arb2 #(
    .FIXED_PRIO (ARP_PRIO)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .req_a_i   (arp_req),
    .req_b_i   (ip_req),
    .advance_i (grant_now),
    .any_o     (any_req),
    .pick_b_o  (pick_ip)
  );

  assign sel_valid = (sel_q == SEL_IP) ? ip_valid : arp_valid;
  assign sel_last  = (sel_q == SEL_IP) ? ip_last  : arp_last;
  assign sel_data  = (sel_q == SEL_IP) ? ip_data  : arp_data;
  // Beat number MAX_LEN is the one presented while MAX_LEN-1 beats are done.
  assign wd_beat   = (beat_q == BEAT_MAX);

  // Payload mux: combinational pass-through in XFER, sink-everything in DRAIN.
  always_comb begin
    mac_data  = 8'h00;
    mac_valid = 1'b0;
    mac_last  = 1'b0;
    sel_ready = 1'b0;
    case (state_q)
      ST_XFER: begin
        mac_data  = sel_data;
        mac_valid = sel_valid;
        mac_last  = sel_last | wd_beat;
        sel_ready = mac_ready;
      end
      ST_DRAIN: begin
        sel_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign xfer_hs   = mac_valid & mac_ready;
  assign owning    = (state_q == ST_START) || (state_q == ST_XFER) ||
                     (state_q == ST_DRAIN);
  assign arp_gnt   = owning & (sel_q == SEL_ARP);
  assign ip_gnt    = owning & (sel_q == SEL_IP);
  assign arp_ready = sel_ready & (sel_q == SEL_ARP);
  assign ip_ready  = sel_ready & (sel_q == SEL_IP);
  assign mac_start = (state_q == ST_START);
  assign mac_da        = da_q;
  assign mac_ethertype = etype_q;
  assign tx_abort      = abort_q;
  assign dbg_state_o   = state_q;

  // Frame FSM with header latch, beat watchdog and inter-frame gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_ARP;
      da_q    <= '0;
      etype_q <= '0;
      beat_q  <= '0;
      ifg_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q <= ST_START;
            sel_q   <= pick_ip;
            da_q    <= pick_ip ? ip_da : arp_da;
            etype_q <= ethertype_of(pick_ip);
            beat_q  <= '0;
          end
        end
        ST_START: begin
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (xfer_hs) begin
            beat_q <= beat_q + 11'd1;
            if (sel_last) begin
              state_q <= ST_IFG;
              ifg_q   <= IFG_LOAD;
            end else if (wd_beat) begin
              state_q <= ST_DRAIN;
              abort_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (sel_valid && sel_last) begin
            state_q <= ST_IFG;
            ifg_q   <= IFG_LOAD;
          end
        end
        ST_IFG: begin
          if (ifg_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            ifg_q <= ifg_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
